// File: rtl/ysyx_25020047_lsu_if.sv
// Execute-stage request, writeback response and data-memory port
// bundled for the load/store unit.
interface ysyx_25020047_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_read;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_read, req_write, req_addr,
        input  req_wdata, req_size, req_unsigned,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        input  resp_ready,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ack, mem_rdata
    );

    modport master (
        output req_valid, req_read, req_write, req_addr,
        output req_wdata, req_size, req_unsigned,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        output resp_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/ysyx_25020047_lsu.sv
// Load/store unit: one outstanding request, byte-strobed word port,
// bounded wait for the memory acknowledge.
module ysyx_25020047_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic                clk,
    input logic                rst,
    ysyx_25020047_lsu_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_RESP
    } state_e;

    localparam logic [15:0] TO = 16'(TIMEOUT);

    state_e      state_q;
    logic [1:0]  addr_lo_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        read_q;
    logic [15:0] cnt_q;
    logic        mem_en_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_wstrb_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;

    logic        misal;
    logic        illegal;
    logic [3:0]  wstrb_d;
    logic [31:0] wdata_d;
    logic [31:0] load_d;
    logic [15:0] cnt_d;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        misal   = 1'b0;
        wstrb_d = 4'b1111;
        wdata_d = bus.req_wdata;
        unique case (bus.req_size)
            2'd0: begin
                wstrb_d = 4'b0001 << bus.req_addr[1:0];
                wdata_d = {4{bus.req_wdata[7:0]}};
            end
            2'd1: begin
                misal   = bus.req_addr[0];
                wstrb_d = 4'b0011 << bus.req_addr[1:0];
                wdata_d = {2{bus.req_wdata[15:0]}};
            end
            2'd2: misal = |bus.req_addr[1:0];
            default: misal = 1'b1;
        endcase
        if (!bus.req_write) wstrb_d = 4'b0000;
        illegal = (bus.req_read == bus.req_write) | misal;
    end

    // Lane select uses the latched low address bits, not the live bus.
    always_comb begin
        lane_b = bus.mem_rdata[{addr_lo_q, 3'b000} +: 8];
        lane_h = bus.mem_rdata[{addr_lo_q[1], 4'b0000} +: 16];
        unique case (size_q)
            2'd0:    load_d = {{24{~uns_q & lane_b[7]}}, lane_b};
            2'd1:    load_d = {{16{~uns_q & lane_h[15]}}, lane_h};
            default: load_d = bus.mem_rdata;
        endcase
        cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_lo_q    <= 2'd0;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            read_q       <= 1'b0;
            cnt_q        <= 16'd0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            mem_wstrb_q  <= 4'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            unique case (state_q)
                S_IDLE: if (bus.req_valid) begin
                    addr_lo_q <= bus.req_addr[1:0];
                    size_q    <= bus.req_size;
                    uns_q     <= bus.req_unsigned;
                    read_q    <= bus.req_read;
                    if (illegal) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= 32'd0;
                    end else begin
                        state_q     <= S_ISSUE;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= bus.req_write;
                        mem_addr_q  <= {bus.req_addr[31:2], 2'b00};
                        mem_wdata_q <= wdata_d;
                        mem_wstrb_q <= wstrb_d;
                    end
                end
                S_ISSUE: begin
                    mem_en_q <= 1'b0;
                    cnt_q    <= 16'd0;
                    state_q  <= S_WAIT;
                end
                // An ack on the final allowed cycle still counts as success.
                S_WAIT: if (bus.mem_ack) begin
                    state_q      <= S_RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= read_q ? load_d : 32'd0;
                end else begin
                    cnt_q <= cnt_d;
                    if (cnt_d >= TO) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= 32'd0;
                    end
                end
                S_RESP: if (bus.resp_ready) begin
                    state_q      <= S_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'd0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state_q == S_IDLE) & ~rst;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_wstrb  = mem_wstrb_q;
endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// Scoreboard bench for the load/store unit with a short timeout
// so the abandon path is reached quickly.
module tb_ysyx_25020047_lsu;
    localparam int TO = 4;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    exp_t sb[$];

    ysyx_25020047_lsu_if bus ();

    ysyx_25020047_lsu #(.TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.resp_valid && bus.resp_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_rdata", bus.resp_rdata, e.rdata);
                chk("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
            end
        end
    end

    task automatic do_req(
        input logic rd, input logic wr, input logic [31:0] addr,
        input logic [31:0] wdata, input logic [1:0] size, input logic uns,
        input int ack_dly, input logic [31:0] mrdata,
        input logic [31:0] exp_rdata, input logic exp_err,
        input logic exp_mem, input logic [3:0] exp_strb,
        input logic [31:0] exp_wdata);
        int k;
        int exp_lat;
        exp_t e;
        chk("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_read     = rd;
        bus.req_write    = wr;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("mem_en", {31'd0, bus.mem_en}, {31'd0, exp_mem});
        if (exp_mem) begin
            chk("mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
            chk("mem_we", {31'd0, bus.mem_we}, {31'd0, wr});
            chk("mem_wstrb", {28'd0, bus.mem_wstrb}, {28'd0, exp_strb});
            if (wr) chk("mem_wdata", bus.mem_wdata, exp_wdata);
        end
        k = 0;
        while (!bus.resp_valid && k < 40) begin
            @(posedge clk); #1;
            k++;
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 32'h0;
            if (!bus.resp_valid) begin
                chk("mem_en_wait", {31'd0, bus.mem_en}, 32'd0);
                chk("mem_addr_hold", bus.mem_addr, {addr[31:2], 2'b00});
                chk("mem_wstrb_hold", {28'd0, bus.mem_wstrb},
                    {28'd0, exp_strb});
                if (k == ack_dly) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mrdata;
                end
            end
        end
        exp_lat = !exp_mem ? 0 : (ack_dly < 0 ? TO + 1 : ack_dly + 1);
        chk("resp_latency", k, exp_lat);
        chk("req_ready_resp", {31'd0, bus.req_ready}, 32'd0);
        if (bus.resp_ready) begin
            @(posedge clk); #1;
            chk("resp_drop", {31'd0, bus.resp_valid}, 32'd0);
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_read = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr = 32'h0;
        bus.req_wdata = 32'h0;
        bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.resp_ready = 1'b1;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'h0;
        #12;
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rel_req_ready", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;

        do_req(1, 0, 32'h8000_0004, 32'h0, 2'd2, 0, 3, 32'hDEAD_BEEF,
               32'hDEAD_BEEF, 0, 1, 4'b0000, 32'h0);
        do_req(1, 0, 32'h8000_0003, 32'h0, 2'd0, 1, 2, 32'h80FF_7F01,
               32'h0000_0080, 0, 1, 4'b0000, 32'h0);
        do_req(1, 0, 32'h8000_0003, 32'h0, 2'd0, 0, 1, 32'h80FF_7F01,
               32'hFFFF_FF80, 0, 1, 4'b0000, 32'h0);
        do_req(1, 0, 32'h8000_0002, 32'h0, 2'd1, 0, 2, 32'h80FF_7F01,
               32'hFFFF_80FF, 0, 1, 4'b0000, 32'h0);
        do_req(1, 0, 32'h8000_0000, 32'h0, 2'd1, 1, 1, 32'h80FF_7F01,
               32'h0000_7F01, 0, 1, 4'b0000, 32'h0);
        do_req(0, 1, 32'h8000_0002, 32'h1234_56AB, 2'd0, 0, 1, 32'h0,
               32'h0, 0, 1, 4'b0100, 32'hABAB_ABAB);
        do_req(0, 1, 32'h8000_0002, 32'hCAFE_1234, 2'd1, 0, 2, 32'h0,
               32'h0, 0, 1, 4'b1100, 32'h1234_1234);
        do_req(0, 1, 32'h8000_0008, 32'hA5A5_0F0F, 2'd2, 0, 1, 32'h0,
               32'h0, 0, 1, 4'b1111, 32'hA5A5_0F0F);
        do_req(1, 0, 32'h8000_0002, 32'h0, 2'd2, 0, 1, 32'h0,
               32'h0, 1, 0, 4'b0000, 32'h0);
        do_req(1, 1, 32'h8000_0000, 32'h0, 2'd2, 0, 1, 32'h0,
               32'h0, 1, 0, 4'b0000, 32'h0);
        do_req(1, 0, 32'h8000_0000, 32'h0, 2'd3, 0, 1, 32'h0,
               32'h0, 1, 0, 4'b0000, 32'h0);
        do_req(0, 1, 32'h8000_0001, 32'h0, 2'd1, 0, 1, 32'h0,
               32'h0, 1, 0, 4'b0000, 32'h0);
        do_req(1, 0, 32'h8000_0010, 32'h0, 2'd2, 0, -1, 32'h0,
               32'h0, 1, 1, 4'b0000, 32'h0);
        do_req(1, 0, 32'h8000_0010, 32'h0, 2'd2, 0, TO, 32'h1122_3344,
               32'h1122_3344, 0, 1, 4'b0000, 32'h0);

        bus.resp_ready = 1'b0;
        do_req(1, 0, 32'h8000_0001, 32'h0, 2'd0, 0, 2, 32'h1234_8056,
               32'hFFFF_FF80, 0, 1, 4'b0000, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", {31'd0, bus.resp_valid}, 32'd1);
            chk("bp_rdata", bus.resp_rdata, 32'hFFFF_FF80);
            chk("bp_err", {31'd0, bus.resp_err}, 32'd0);
            chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", {31'd0, bus.resp_valid}, 32'd0);

        bus.req_valid = 1'b1;
        bus.req_read = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr = 32'h8000_0020;
        bus.req_size = 2'd2;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("mr_issue", {31'd0, bus.mem_en}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mr_mem_en", {31'd0, bus.mem_en}, 32'd0);
        chk("mr_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("mr_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("mr_mem_addr", bus.mem_addr, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("mr_stray_ack", {31'd0, bus.resp_valid}, 32'd0);
            @(posedge clk); #1;
        end
        chk("mr_idle_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("sb_left", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
